// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int DEFAULT_TIMEOUT = 255;

  // The bus only ever sees word addresses; lane selection is carried by the mask.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational natural-alignment check for halfword and word accesses.
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       misaligned
);

  // The reserved size encoding behaves exactly like a word access.
  always_comb begin
    misaligned = 1'b0;
    if (size == SZ_H)
      misaligned = addr[0];
    else if ((size == SZ_W) || (size == 2'd3))
      misaligned = (addr != 2'b00);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one operation at a time over a single-outstanding data bus.
// Optional alignment fault checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        out_timeout,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wmask,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          misaligned;
  logic          is_mem;
  logic          timed_out;
  logic          is_load_q;
  logic          req_wen;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wmask;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          timeout_q;

`ifdef LSU_MISALIGN_CHECK_EN
  lsu_align_chk u_align_chk (
    .addr       (in_addr[1:0]),
    .size       (in_size),
    .misaligned (misaligned)
  );
`else
  // Without the check the low address bits and size never influence control.
  assign misaligned = 1'b0 & (^{in_size, in_addr[1:0]});
`endif

  assign is_mem    = in_is_load | in_is_store;
  // The counter value seen now becomes TIMEOUT at the end of this cycle.
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem || misaligned)
            state_next = RESP;
          else
            state_next = REQ;
        end
      end
      REQ:     if (bus_req_ready) state_next = WAIT;
      WAIT:    if (bus_rsp_valid || timed_out) state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at accept so they stay stable through REQ;
  // result fields are cleared at accept and only written when leaving WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      is_load_q <= 1'b0;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_load_q <= in_is_load;
            req_wen   <= in_is_store;
            req_addr  <= word_addr(in_addr);
            req_wdata <= in_wdata;
            req_wmask <= in_is_store ? in_wmask : 4'b0000;
            rdata_q   <= '0;
            err_q     <= is_mem & misaligned;
            timeout_q <= 1'b0;
          end
        end
        REQ: begin
          if (bus_req_ready)
            cnt <= '0;
        end
        WAIT: begin
          if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
          // A response in the final counted cycle takes priority over the timeout.
          if (bus_rsp_valid) begin
            if (is_load_q)
              rdata_q <= bus_rsp_rdata;
            err_q <= bus_rsp_err;
          end else if (timed_out) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == RESP);
  assign bus_req_valid = (state == REQ);
  assign bus_req_wen   = req_wen;
  assign bus_req_addr  = req_addr;
  assign bus_req_wdata = req_wdata;
  assign bus_req_wmask = req_wmask;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign out_timeout   = timeout_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: transaction-level reference model plus directed and random operations.
module tb_lsu;

  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_wmask;
  logic        out_valid, out_ready, out_err, out_timeout;
  logic [31:0] out_rdata;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wmask;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [31:0] bus_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.TIMEOUT(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_size       (in_size),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_wmask      (in_wmask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err),
    .out_timeout   (out_timeout),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_wen   (bus_req_wen),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wmask (bus_req_wmask),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 free, 1 requesting, 2 awaiting response, 3 result held.
  int          m_phase = 0;
  int          m_waits = 0;
  bit          m_started = 0;
  bit          m_after_reset = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;
  logic        m_wen, m_is_load, m_err, m_to;

  function automatic bit expect_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase       <= 0;
      m_waits       <= 0;
      m_started     <= 1;
      m_after_reset <= 1;
    end else begin
      m_after_reset <= 0;
      case (m_phase)
        0: if (in_valid) begin
          m_addr    <= in_addr - (in_addr % 4);
          m_wen     <= in_is_store;
          m_wdata   <= in_wdata;
          m_wmask   <= in_is_store ? in_wmask : 4'd0;
          m_is_load <= in_is_load;
          m_rdata   <= 0;
          m_to      <= 0;
          if (!in_is_load && !in_is_store) begin
            m_phase <= 3; m_err <= 0;
          end else if (expect_misaligned(in_size, in_addr)) begin
            m_phase <= 3; m_err <= 1;
          end else begin
            m_phase <= 1; m_err <= 0;
          end
        end
        1: if (bus_req_ready) begin
          m_phase <= 2;
          m_waits <= 0;
        end
        2: begin
          if (bus_rsp_valid) begin
            m_phase <= 3;
            m_rdata <= m_is_load ? bus_rsp_rdata : 32'd0;
            m_err   <= bus_rsp_err;
            m_to    <= 0;
          end else if (m_waits + 1 >= T) begin
            m_phase <= 3; m_rdata <= 0; m_err <= 1; m_to <= 1;
          end else begin
            m_waits <= m_waits + 1;
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      checkOutput("in_ready", in_ready, m_phase == 0);
      checkOutput("out_valid", out_valid, m_phase == 3);
      checkOutput("bus_req_valid", bus_req_valid, m_phase == 1);
      if (m_after_reset) begin
        checkOutput("rst_out_rdata", out_rdata, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_out_timeout", out_timeout, 0);
        checkOutput("rst_req_wen", bus_req_wen, 0);
        checkOutput("rst_req_addr", bus_req_addr, 0);
        checkOutput("rst_req_wdata", bus_req_wdata, 0);
        checkOutput("rst_req_wmask", bus_req_wmask, 0);
      end else if (m_phase == 1) begin
        checkOutput("req_addr", bus_req_addr, m_addr);
        checkOutput("req_wen", bus_req_wen, m_wen);
        checkOutput("req_wmask", bus_req_wmask, m_wmask);
        if (m_wen) checkOutput("req_wdata", bus_req_wdata, m_wdata);
      end else if (m_phase == 3) begin
        checkOutput("out_rdata", out_rdata, m_rdata);
        checkOutput("out_err", out_err, m_err);
        checkOutput("out_timeout", out_timeout, m_to);
      end
    end
  end

  int          cyc = 0;
  int          out_cyc = -1;
  bit          seen_out = 0;
  bit          r_saw_req;
  logic [31:0] r_req_addr, r_rdata;
  logic [3:0]  r_req_wmask;
  logic        r_req_wen, r_err, r_to;
  int          r_lat, r_hs_lat;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid && !seen_out) begin
      seen_out = 1;
      out_cyc  = cyc;
    end
  endtask

  // Runs one operation end to end; r_lat counts cycles from accept (cycle 0) to first
  // out_valid, r_hs_lat counts edges from the request handshake to the result edge.
  task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input int req_delay, input int rsp_delay,
                               input logic rerr, input logic [31:0] rdata, input int out_delay);
    int acc, hs;
    seen_out = 0; out_cyc = -1; r_saw_req = 0; hs = -1;
    in_valid = 1; in_is_load = ld; in_is_store = st; in_size = sz;
    in_addr = addr; in_wdata = wdata; in_wmask = wmask;
    tick();
    acc = cyc;
    in_valid = 0; in_is_load = 0; in_is_store = 0;
    for (int i = 0; i < 10 && !bus_req_valid && !out_valid; i++) tick();
    if (bus_req_valid) begin
      r_saw_req = 1; r_req_addr = bus_req_addr; r_req_wen = bus_req_wen; r_req_wmask = bus_req_wmask;
      for (int i = 0; i < req_delay; i++) begin
        bus_rsp_valid = 1'($urandom_range(0, 1));
        bus_rsp_rdata = $urandom;
        bus_rsp_err   = 1'($urandom_range(0, 1));
        tick();
      end
      bus_rsp_valid = 0; bus_rsp_err = 0; bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      hs = cyc;
      for (int i = 0; i < rsp_delay; i++) tick();
      bus_rsp_valid = 1; bus_rsp_err = rerr; bus_rsp_rdata = rdata;
      tick();
      bus_rsp_valid = 0; bus_rsp_err = 0;
    end else begin
      checkOutput("progress", out_valid, 1);
    end
    for (int i = 0; i < 3 * T && !out_valid; i++) tick();
    checkOutput("result_reached", out_valid, 1);
    for (int i = 0; i < out_delay; i++) tick();
    r_rdata = out_rdata; r_err = out_err; r_to = out_timeout;
    r_lat = out_cyc - acc + 1;
    r_hs_lat = out_cyc - hs;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0;
    in_addr = 0; in_wdata = 0; in_wmask = 0; out_ready = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    checkOutput("lit_reset_in_ready", in_ready, 1);
    checkOutput("lit_reset_out_valid", out_valid, 0);

    $display("[TB] load word, best-case latency");
    applyStimulus(1, 0, 2'd2, 32'h8000_0100, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    checkOutput("lw_req_addr", r_req_addr, 32'h8000_0100);
    checkOutput("lw_req_wmask", r_req_wmask, 0);
    checkOutput("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_err", r_err, 0);
    checkOutput("lw_latency", r_lat, 3);

    $display("[TB] store byte with delayed request acceptance");
    applyStimulus(0, 1, 2'd0, 32'h8000_0203, 32'hAB00_0000, 4'b1000, 4, 1, 0, 32'h1111_1111, 0);
    checkOutput("sb_req_addr", r_req_addr, 32'h8000_0200);
    checkOutput("sb_req_wen", r_req_wen, 1);
    checkOutput("sb_req_wmask", r_req_wmask, 4'b1000);
    checkOutput("sb_rdata", r_rdata, 0);

    $display("[TB] timeout with a late response during the result hold");
    applyStimulus(1, 0, 2'd2, 32'h8000_0300, 32'h0, 4'h0, 1, T, 0, 32'h55AA_55AA, 2);
    checkOutput("to_err", r_err, 1);
    checkOutput("to_flag", r_to, 1);
    checkOutput("to_rdata", r_rdata, 0);
    checkOutput("to_edges_after_handshake", r_hs_lat, T);

    $display("[TB] response in the final counted cycle wins");
    applyStimulus(1, 0, 2'd2, 32'h8000_0304, 32'h0, 4'h0, 0, T - 1, 0, 32'hCAFE_F00D, 0);
    checkOutput("edge_err", r_err, 0);
    checkOutput("edge_timeout", r_to, 0);
    checkOutput("edge_rdata", r_rdata, 32'hCAFE_F00D);
    checkOutput("edge_edges_after_handshake", r_hs_lat, T);

    $display("[TB] bus error on a load");
    applyStimulus(1, 0, 2'd2, 32'h8000_0400, 32'h0, 4'h0, 0, 2, 1, 32'h1234_5678, 0);
    checkOutput("be_err", r_err, 1);
    checkOutput("be_timeout", r_to, 0);
    checkOutput("be_rdata", r_rdata, 32'h1234_5678);

    $display("[TB] misaligned load word");
    applyStimulus(1, 0, 2'd2, 32'h8000_0002, 32'h0, 4'h0, 0, 0, 0, 32'h0BAD_0BAD, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    checkOutput("mis_saw_req", r_saw_req, 0);
    checkOutput("mis_err", r_err, 1);
    checkOutput("mis_timeout", r_to, 0);
    checkOutput("mis_latency", r_lat, 1);
`else
    checkOutput("mis_req_addr", r_req_addr, 32'h8000_0000);
    checkOutput("mis_err", r_err, 0);
    checkOutput("mis_rdata", r_rdata, 32'h0BAD_0BAD);
    checkOutput("mis_latency", r_lat, 3);
`endif

    $display("[TB] operation with neither load nor store");
    applyStimulus(0, 0, 2'd2, 32'h8000_0500, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 32'h0, 0);
    checkOutput("nop_saw_req", r_saw_req, 0);
    checkOutput("nop_err", r_err, 0);
    checkOutput("nop_rdata", r_rdata, 0);
    checkOutput("nop_latency", r_lat, 1);

    $display("[TB] result backpressure");
    applyStimulus(1, 0, 2'd1, 32'h8000_0602, 32'h0, 4'h0, 0, 1, 0, 32'h0102_0304, 5);
    checkOutput("bp_rdata", r_rdata, 32'h0102_0304);

    $display("[TB] reset while awaiting a response");
    in_valid = 1; in_is_load = 1; in_size = 2'd2; in_addr = 32'h8000_0700;
    tick();
    in_valid = 0; in_is_load = 0; bus_req_ready = 1;
    tick();
    bus_req_ready = 0;
    tick();
    rst_n = 0;
    tick();
    checkOutput("rw_in_ready", in_ready, 1);
    checkOutput("rw_out_valid", out_valid, 0);
    checkOutput("rw_req_valid", bus_req_valid, 0);
    checkOutput("rw_req_addr", bus_req_addr, 0);
    checkOutput("rw_out_err", out_err, 0);
    rst_n = 1; bus_rsp_valid = 1; bus_rsp_rdata = 32'h7777_7777;
    tick();
    bus_rsp_valid = 0;
    checkOutput("rw_no_replay", out_valid, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      applyStimulus(kind < 5, kind >= 5 && kind < 9, 2'($urandom_range(0, 3)), a, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, T + 1),
                    $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        bus_rsp_valid = 1; bus_rsp_rdata = $urandom;
        tick();
        bus_rsp_valid = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
